load_store_unit: RTL and testbench

- Initiator side of the CPU data-memory interface. Accepts one load/store request at a time from the execute/memory stage over a valid/ready handshake.
- Checks alignment, then drives memRead/memWrite/address/writeData/Byte_Warning toward data memory and waits a fixed memory latency.
- Extracts and sign/zero-extends the addressed byte or halfword, and returns a single-cycle response to the pipeline, which stalls while req_ready is low.

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - initiator side of the CPU data-memory interface
//
// Takes one load/store at a time over req_valid/req_ready. It checks alignment,
// drives the data-memory strobes, waits MEM_LATENCY extra cycles for loads and
// returns a one-cycle response. Load data is sign- or zero-extended.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake (accept on valid && ready)
//   req_is_store, req_size,         request fields, latched on accept
//   req_signed, req_addr, req_wdata
//   resp_valid, resp_rdata,         one-cycle response; rdata/fault held until next
//   resp_fault
//   memRead, memWrite, address,     data-memory side; address/writeData/Byte_Warning
//   writeData, Byte_Warning,        hold their last value while idle
//   readData
module load_store_unit #(
  parameter int MEM_LATENCY = 0,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic [1:0]  Byte_Warning,
  input  logic [31:0] readData
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  // Counter value on which readData is sampled in WAIT.
  localparam int LAST_I = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
  localparam logic [CNT_W-1:0] LAST = LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic              is_store_q, signed_q;
  logic [1:0]        size_q, lane_q;
  logic [31:0]       addr_q, wdata_q;
  logic [1:0]        bw_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              fault_q;

  logic              accept, fault_in, load_done;
  logic [31:0]       store_data;

  function automatic logic [31:0] extend(input logic [31:0] word,
                                         input logic [1:0]  lane,
                                         input logic [1:0]  size,
                                         input logic        sgn);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b10:   extend = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      2'b01:   extend = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: extend = word;
    endcase
  endfunction

  assign accept   = req_valid && (state == IDLE);
  assign fault_in = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b00 && req_addr[1:0] != 2'b00);

  // Narrow stores are replicated across all lanes so the memory can pick its lane.
  always_comb begin
    store_data = req_wdata;
    case (req_size)
      2'b10:   store_data = {4{req_wdata[7:0]}};
      2'b01:   store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase
  end

  assign load_done = !is_store_q &&
                     ((state == ACCESS && MEM_LATENCY == 0) ||
                      (state == WAIT && cnt_q == LAST));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = fault_in ? RESP : ACCESS;
      ACCESS: state_nxt = (is_store_q || MEM_LATENCY == 0) ? RESP : WAIT;
      WAIT:   if (cnt_q == LAST) state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      addr_q     <= 32'b0;
      wdata_q    <= 32'b0;
      bw_q       <= 2'b00;
      cnt_q      <= '0;
      rdata_q    <= 32'b0;
      fault_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_store_q <= req_is_store;
        signed_q   <= req_signed;
        size_q     <= req_size;
        lane_q     <= req_addr[1:0];
        if (fault_in) begin
          rdata_q <= 32'b0;
          fault_q <= 1'b1;
        end else if (req_is_store) begin
          addr_q  <= req_addr;
          bw_q    <= req_size;
          wdata_q <= store_data;
        end else begin
          // Loads always fetch the whole aligned word and extract locally.
          addr_q <= {req_addr[31:2], 2'b00};
          bw_q   <= 2'b00;
        end
      end
      if (state == ACCESS) cnt_q <= '0;
      else if (state == WAIT) cnt_q <= cnt_q + ONE;
      if (state == ACCESS && is_store_q) begin
        rdata_q <= 32'b0;
        fault_q <= 1'b0;
      end
      if (load_done) begin
        rdata_q <= extend(readData, lane_q, size_q, signed_q);
        fault_q <= 1'b0;
      end
    end
  end

  // All outputs are forced low for as long as reset is held.
  assign req_ready    = !reset && (state == IDLE);
  assign resp_valid   = !reset && (state == RESP);
  assign resp_rdata   = reset ? 32'b0 : rdata_q;
  assign resp_fault   = !reset && fault_q;
  assign memRead      = !reset && ((state == ACCESS && !is_store_q) || state == WAIT);
  assign memWrite     = !reset && (state == ACCESS) && is_store_q;
  assign address      = reset ? 32'b0 : addr_q;
  assign writeData    = reset ? 32'b0 : wdata_q;
  assign Byte_Warning = reset ? 2'b00 : bw_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_is_store, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rv0, rdy0, resp_valid0, fault0, mr0, mw0;
  logic [31:0] rdata0, address0, wd0, readData0;
  logic [1:0]  bw0;

  logic        rv3, rdy3, resp_valid3, fault3, mr3, mw3;
  logic [31:0] rdata3, address3, wd3, readData3;
  logic [1:0]  bw3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.MEM_LATENCY(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv0), .req_ready(rdy0),
    .req_is_store(req_is_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_rdata(rdata0), .resp_fault(fault0),
    .memRead(mr0), .memWrite(mw0), .address(address0), .writeData(wd0),
    .Byte_Warning(bw0), .readData(readData0)
  );

  load_store_unit #(.MEM_LATENCY(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(rv3), .req_ready(rdy3),
    .req_is_store(req_is_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid3), .resp_rdata(rdata3), .resp_fault(fault3),
    .memRead(mr3), .memWrite(mw3), .address(address3), .writeData(wd3),
    .Byte_Warning(bw3), .readData(readData3)
  );

  // Zero-latency memory for dut0: combinational read, write committed on negedge.
  assign readData0 = mem[address0[13:2]];
  always @(negedge clk) begin
    if (mw0) begin
      case (bw0)
        2'b00: mem[address0[13:2]] <= wd0;
        2'b01: if (address0[1]) mem[address0[13:2]][31:16] <= wd0[31:16];
               else             mem[address0[13:2]][15:0]  <= wd0[15:0];
        2'b10: case (address0[1:0])
                 2'b00: mem[address0[13:2]][7:0]   <= wd0[7:0];
                 2'b01: mem[address0[13:2]][15:8]  <= wd0[15:8];
                 2'b10: mem[address0[13:2]][23:16] <= wd0[23:16];
                 default: mem[address0[13:2]][31:24] <= wd0[31:24];
               endcase
        default: ;
      endcase
    end
  end

  // Slow memory for dut3 returns a different word every cycle.
  function automatic logic [31:0] f3(input int c);
    logic [31:0] cv;
    cv = 32'(c);
    return {16'hC0DE, cv[15:0]};
  endfunction
  assign readData3 = f3(cyc);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic        efault;
    logic [31:0] erd;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [1:0]  ebw;
    int          elat;
  } vec_t;

  vec_t vecs [17];

  task automatic run0(input vec_t v, input int idx);
    int lat, nrd, nwr, guard;
    logic [31:0] cap_a, cap_wd;
    logic [1:0]  cap_bw;
    logic        cap_f;
    logic [31:0] cap_rd;
    req_is_store = v.st; req_size = v.sz; req_signed = v.sg;
    req_addr = v.a; req_wdata = v.wd; rv0 = 1'b1;
    guard = 0;
    while (!rdy0 && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    rv0 = 1'b0;
    lat = 0; nrd = 0; nwr = 0;
    cap_a = 32'b0; cap_wd = 32'b0; cap_bw = 2'b00; cap_f = 1'b0; cap_rd = 32'hFFFF_FFFF;
    for (int k = 0; k < 20; k++) begin
      if (mw0) begin nwr++; cap_a = address0; cap_wd = wd0; cap_bw = bw0; end
      if (mr0) begin nrd++; cap_a = address0; cap_bw = bw0; end
      if (resp_valid0) begin lat = k + 1; cap_f = fault0; cap_rd = rdata0; break; end
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.elat));
    chk($sformatf("v%0d fault", idx), {31'b0, cap_f}, {31'b0, v.efault});
    chk($sformatf("v%0d rdata", idx), cap_rd, v.erd);
    chk($sformatf("v%0d memWrite cycles", idx), 32'(nwr), (v.st && !v.efault) ? 32'd1 : 32'd0);
    chk($sformatf("v%0d memRead cycles", idx), 32'(nrd), (!v.st && !v.efault) ? 32'd1 : 32'd0);
    if (!v.efault) begin
      chk($sformatf("v%0d address", idx), cap_a, v.eaddr);
      chk($sformatf("v%0d Byte_Warning", idx), {30'b0, cap_bw}, {30'b0, v.ebw});
      if (v.st) chk($sformatf("v%0d writeData", idx), cap_wd, v.ewd);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d resp_valid drops", idx), {31'b0, resp_valid0}, 32'd0);
    chk($sformatf("v%0d rdata held", idx), rdata0, v.erd);
  endtask

  // Runs one request on dut3; fields must already be set. With hold=1 req_valid stays high.
  task automatic run3(input logic hold, output int lat, output int nrd,
                      output logic [31:0] rd, output int c0, output int busy_rdy);
    int guard;
    rv3 = 1'b1;
    guard = 0;
    while (!rdy3 && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    if (!hold) rv3 = 1'b0;
    c0 = cyc; lat = 0; nrd = 0; rd = 32'hFFFF_FFFF; busy_rdy = 0;
    for (int k = 0; k < 20; k++) begin
      if (mr3) nrd++;
      if (rdy3) busy_rdy++;
      if (resp_valid3) begin lat = k + 1; rd = rdata3; break; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nrd, c0, busy;
    logic [31:0] rd;

    for (int i = 0; i < 4096; i++) mem[i] = 32'b0;
    mem[12'h400] = 32'h1111_1111;
    mem[12'h800] = 32'h80FF_7F01;

    //          st    sz     sg    addr          wdata         flt   rdata         eaddr         ewd           bw     lat
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 32'h0,        32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 2};
    vecs[1]  = '{1'b1, 2'b10, 1'b0, 32'h0000_1003, 32'h1234_56A5, 1'b0, 32'h0,        32'h0000_1003, 32'hA5A5_A5A5, 2'b10, 2};
    vecs[2]  = '{1'b1, 2'b01, 1'b0, 32'h0000_1002, 32'h0000_BEEF, 1'b0, 32'h0,        32'h0000_1002, 32'hBEEF_BEEF, 2'b01, 2};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 32'hBEEF_BEEF, 32'h0000_1000, 32'h0,        2'b00, 2};
    vecs[4]  = '{1'b0, 2'b10, 1'b1, 32'h0000_1001, 32'h0,         1'b0, 32'hFFFF_FFBE, 32'h0000_1000, 32'h0,        2'b00, 2};
    vecs[5]  = '{1'b0, 2'b10, 1'b1, 32'h0000_2003, 32'h0,         1'b0, 32'hFFFF_FF80, 32'h0000_2000, 32'h0,        2'b00, 2};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_2003, 32'h0,         1'b0, 32'h0000_0080, 32'h0000_2000, 32'h0,        2'b00, 2};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,         1'b0, 32'hFFFF_80FF, 32'h0000_2000, 32'h0,        2'b00, 2};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_2000, 32'h0,         1'b0, 32'h0000_7F01, 32'h0000_2000, 32'h0,        2'b00, 2};
    vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'h0000_2000, 32'h0,         1'b0, 32'h80FF_7F01, 32'h0000_2000, 32'h0,        2'b00, 2};
    vecs[10] = '{1'b0, 2'b10, 1'b1, 32'h0000_2001, 32'h0,         1'b0, 32'h0000_007F, 32'h0000_2000, 32'h0,        2'b00, 2};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,         1'b0, 32'h0000_80FF, 32'h0000_2000, 32'h0,        2'b00, 2};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h0000_1002, 32'h0,         1'b1, 32'h0,        32'h0,        32'h0,        2'b00, 1};
    vecs[13] = '{1'b0, 2'b01, 1'b1, 32'h0000_1001, 32'h0,         1'b1, 32'h0,        32'h0,        32'h0,        2'b00, 1};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 32'h0000_2000, 32'h0,         1'b1, 32'h0,        32'h0,        32'h0,        2'b00, 1};
    vecs[15] = '{1'b1, 2'b00, 1'b0, 32'h0000_1001, 32'h5555_5555, 1'b1, 32'h0,        32'h0,        32'h0,        2'b00, 1};
    vecs[16] = '{1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 32'hBEEF_BEEF, 32'h0000_1000, 32'h0,        2'b00, 2};

    reset = 1'b1; rv0 = 1'b0; rv3 = 1'b0;
    req_is_store = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'b0; req_wdata = 32'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset req_ready0", {31'b0, rdy0}, 32'd0);
    chk("reset req_ready3", {31'b0, rdy3}, 32'd0);
    chk("reset strobes0", {30'b0, mr0, mw0}, 32'd0);
    chk("reset resp_valid0", {31'b0, resp_valid0}, 32'd0);
    chk("reset address0", address0, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post-reset req_ready0", {31'b0, rdy0}, 32'd1);
    chk("post-reset req_ready3", {31'b0, rdy3}, 32'd1);

    for (int i = 0; i < 17; i++) run0(vecs[i], i);

    // Latency-3 load with req_valid held: second accept only after RESP.
    req_is_store = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h40;
    run3(1'b1, lat, nrd, rd, c0, busy);
    chk("lat3 latency", 32'(lat), 32'd5);
    chk("lat3 memRead cycles", 32'(nrd), 32'd4);
    chk("lat3 rdata", rd, f3(c0 + 3));
    chk("lat3 fault", {31'b0, fault3}, 32'd0);
    chk("lat3 ready while busy", 32'(busy), 32'd0);
    chk("lat3 Byte_Warning", {30'b0, bw3}, 32'd0);
    @(posedge clk); #1;
    chk("lat3 ready after resp", {31'b0, rdy3}, 32'd1);
    chk("lat3 no early re-accept", {31'b0, mr3}, 32'd0);
    @(posedge clk); #1;
    chk("lat3 second accept", {31'b0, mr3}, 32'd1);
    c0 = cyc; rv3 = 1'b0; lat = 0; rd = 32'hFFFF_FFFF;
    for (int k = 0; k < 20; k++) begin
      if (resp_valid3) begin lat = k + 1; rd = rdata3; break; end
      @(posedge clk); #1;
    end
    chk("lat3 second latency", 32'(lat), 32'd5);
    chk("lat3 second rdata", rd, f3(c0 + 3));
    @(posedge clk); #1;

    // Reset during WAIT abandons the load.
    rv3 = 1'b1;
    @(posedge clk); #1;
    rv3 = 1'b0;
    @(posedge clk); #1;
    chk("abort in WAIT memRead", {31'b0, mr3}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort reset memRead", {31'b0, mr3}, 32'd0);
    @(posedge clk); #1;
    chk("abort after edge memRead", {31'b0, mr3}, 32'd0);
    chk("abort no resp", {31'b0, resp_valid3}, 32'd0);
    reset = 1'b0;
    busy = 0;
    @(posedge clk); #1;
    chk("abort ready after reset", {31'b0, rdy3}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (resp_valid3 || mr3) busy++;
      @(posedge clk); #1;
    end
    chk("abort stays quiet", 32'(busy), 32'd0);
    run3(1'b0, lat, nrd, rd, c0, busy);
    chk("after abort latency", 32'(lat), 32'd5);
    chk("after abort rdata", rd, f3(c0 + 3));
    chk("after abort memRead cycles", 32'(nrd), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
